// File: rtl/four_bit_spi_receiver_pkg.sv
// Shared constants for the SPI receiver: FSM encoding, frame size limit and lane modes.
// Lane-mode values match the four_bit_spi transmitter so both ends agree on four_bit.
package four_bit_spi_receiver_pkg;

  localparam int MAX_BITS = 64;
  localparam int CNT_W    = 7;

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_BITS);

  localparam logic LANE_1BIT = 1'b0;
  localparam logic LANE_4BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits consumed per sclk rising edge in the given lane mode.
  function automatic logic [CNT_W-1:0] lane_step(input logic mode);
    return (mode == LANE_4BIT) ? CNT_W'(4) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/four_bit_spi_receiver_sync.sv
// N-stage synchronizer with one-cycle rise/fall strobes; latency STAGES clocks, no backpressure.
// Strobes stay quiet until the chain and history hold real samples after reset.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   fill;

  if (STAGES < 2) begin : g_bad_depth
    $error("sync_edge: STAGES must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      fill  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      fill  <= {fill[STAGES-1:0], 1'b1};
    end
  end

  // Without the fill gate, a line held opposite to RESET_VAL would look like an edge after reset.
  assign level = chain[STAGES-1];
  assign rise  = fill[STAGES] & level & ~prev;
  assign fall  = fill[STAGES] & ~level & prev;

endmodule

// File: rtl/four_bit_spi_receiver.sv
// SPI slave receiver, 1- or 4-lane, frames up to 64 bits; valid pulses SYNC_STAGES+2 clocks after cs rises.
// No backpressure: results are presented for one cycle and held until the next frame completes.
module four_bit_spi_receiver
  import four_bit_spi_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cs,
  input  logic                sclk,
  input  logic [3:0]          sdio,
  input  logic                four_bit,
  input  logic [5:0]          bits_expected,
  output logic                busy,
  output logic [MAX_BITS-1:0] data_out,
  output logic [CNT_W-1:0]    bit_count,
  output logic                valid,
  output logic                error,
  output logic                overflow
);

  logic cs_level, cs_fall, cs_rise_unused;
  logic sclk_rise, sclk_level_unused, sclk_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clock),
    .reset (reset),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise_unused),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clock),
    .reset (reset),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  // Same depth as sclk so data lines up with the detected rising edge.
  logic [3:0] sdio_pipe [SYNC_STAGES];
  logic [3:0] sdio_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sdio_pipe[i] <= '0;
    end else begin
      sdio_pipe[0] <= sdio;
      for (int i = 1; i < SYNC_STAGES; i++) sdio_pipe[i] <= sdio_pipe[i-1];
    end
  end

  assign sdio_s = sdio_pipe[SYNC_STAGES-1];

  state_t              state;
  logic [MAX_BITS-1:0] shreg;
  logic [CNT_W-1:0]    count;
  logic                ovf_int;
  logic                mode_q;
  logic [5:0]          expect_q;

  logic [MAX_BITS-1:0] shifted;
  logic [CNT_W-1:0]    sum;
  logic                start;

  always_comb begin
    shifted = shreg;
    if (mode_q == LANE_4BIT) shifted = {shreg[MAX_BITS-5:0], sdio_s};
    else                     shifted = {shreg[MAX_BITS-2:0], sdio_s[0]};
  end

  // count never exceeds 64 and a step is at most 4, so the sum fits in CNT_W bits.
  assign sum   = count + lane_step(mode_q);
  assign start = cs_fall && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      count     <= '0;
      ovf_int   <= 1'b0;
      mode_q    <= LANE_1BIT;
      expect_q  <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      data_out  <= '0;
      bit_count <= '0;
      error     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // cs wins over a coincident sclk edge, which is dropped.
          if (cs_level) begin
            state <= ST_DONE;
          end else if (sclk_rise) begin
            shreg <= shifted;
            if (sum > MAX_COUNT) begin
              count   <= MAX_COUNT;
              ovf_int <= 1'b1;
            end else begin
              count <= sum;
            end
          end
        end
        ST_DONE: begin
          data_out  <= shreg;
          bit_count <= count;
          error     <= (count != {1'b0, expect_q});
          overflow  <= ovf_int;
          valid     <= 1'b1;
          busy      <= cs_fall;
          state     <= cs_fall ? ST_SHIFT : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (start) begin
        shreg    <= '0;
        count    <= '0;
        ovf_int  <= 1'b0;
        mode_q   <= four_bit;
        expect_q <= bits_expected;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_spi_receiver.sv
// Randomised frame driver plus a bit-queue reference model checked every cycle against the receiver.
module tb_four_bit_spi_receiver;

  localparam int SYNC = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic [3:0]  sdio = 4'h0;
  logic        four_bit = 1'b0;
  logic [5:0]  bits_expected = 6'd0;
  logic        busy, valid, error, overflow;
  logic [63:0] data_out;
  logic [6:0]  bit_count;

  four_bit_spi_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clock         (clock),
    .reset         (reset),
    .cs            (cs),
    .sclk          (sclk),
    .sdio          (sdio),
    .four_bit      (four_bit),
    .bits_expected (bits_expected),
    .busy          (busy),
    .data_out      (data_out),
    .bit_count     (bit_count),
    .valid         (valid),
    .error         (error),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic [6:0]  cnt;
    bit          err;
    bit          ovf;
  } exp_t;

  int   cyc = 0;
  bit   rst_at_edge = 1'b0;
  exp_t exp_q[$];
  int   busy_q[$];
  bit   wb[$];

  int checks = 0;
  int failures = 0;
  int valids = 0;

  logic [63:0] exp_data = '0;
  logic [6:0]  exp_cnt = '0;
  bit          exp_err = 1'b0, exp_ovf = 1'b0, exp_busy = 1'b0;
  logic [63:0] last_data = '0;
  logic [6:0]  last_cnt = '0;
  bit          last_err = 1'b0, last_ovf = 1'b0;

  always @(posedge clock) begin
    cyc++;
    rst_at_edge = reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame result from the wire bits alone: the last 64 bits sent, MSB-first.
  function automatic exp_t model(input int due, input int be);
    exp_t r;
    int total, n;
    total  = wb.size();
    n      = (total > 64) ? 64 : total;
    r.due  = due;
    r.data = '0;
    for (int i = 0; i < n; i++) r.data[i] = wb[total-1-i];
    r.cnt  = 7'(n);
    r.ovf  = (total > 64);
    r.err  = (n != be);
    return r;
  endfunction

  always @(negedge clock) begin : compare
    bit due;
    if (rst_at_edge) begin
      exp_q.delete();
      busy_q.delete();
      exp_data = '0; exp_cnt = '0; exp_err = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0;
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_data", data_out, 64'd0);
      check("reset_count", 64'(bit_count), 64'd0);
      check("reset_error", 64'(error), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
    end else begin
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (due) begin
        exp_data = exp_q[0].data;
        exp_cnt  = exp_q[0].cnt;
        exp_err  = exp_q[0].err;
        exp_ovf  = exp_q[0].ovf;
        exp_busy = 1'b0;
        void'(exp_q.pop_front());
      end
      if (busy_q.size() > 0 && busy_q[0] == cyc) begin
        exp_busy = 1'b1;
        void'(busy_q.pop_front());
      end
      check("valid", 64'(valid), 64'(due));
      check("busy", 64'(busy), 64'(exp_busy));
      check("data_out", data_out, exp_data);
      check("bit_count", 64'(bit_count), 64'(exp_cnt));
      check("error", 64'(error), 64'(exp_err));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      if (valid === 1'b1) begin
        valids++;
        last_data = data_out;
        last_cnt  = bit_count;
        last_err  = error;
        last_ovf  = overflow;
      end
    end
  end

  // One cs-low window; abort_at >= 0 pulses reset before that edge and keeps clocking with cs low.
  task automatic frame(input bit mode, input int be, input int edges, input logic [127:0] payload,
                       input int abort_at, input int gap);
    int         total;
    bit         aborted;
    logic [3:0] nib;
    total   = edges * (mode ? 4 : 1);
    aborted = 1'b0;
    wb.delete();
    four_bit      = mode;
    bits_expected = 6'(be);
    cs            = 1'b0;
    busy_q.push_back(cyc + SYNC + 1);
    wait_clk(SYNC + 2);
    four_bit      = 1'($urandom);
    bits_expected = 6'($urandom);
    for (int e = 0; e < edges; e++) begin
      if (e == abort_at) begin
        reset = 1'b1;
        wait_clk(2);
        reset   = 1'b0;
        aborted = 1'b1;
      end
      if (mode) nib = payload[total-1-4*e -: 4];
      else      nib = {3'($urandom), payload[total-1-e]};
      sdio = nib;
      wait_clk(2);
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
      if (!aborted) begin
        if (mode) for (int k = 3; k >= 0; k--) wb.push_back(nib[k]);
        else      wb.push_back(nib[0]);
      end
      wait_clk(1);
    end
    wait_clk(2);
    cs = 1'b1;
    if (!aborted) exp_q.push_back(model(cyc + SYNC + 2, be));
    wait_clk(gap);
  endtask

  initial begin : main
    int          v0, mode, edges, total, be;
    logic [127:0] pl;

    wait_clk(4);
    reset = 1'b0;
    wait_clk(SYNC + 3);

    v0 = valids;
    frame(1'b0, 40, 40, 128'h98_7654_3210, -1, 6);
    wait_clk(SYNC + 4);
    check("lb1_valids", 64'(valids - v0), 64'd1);
    check("lb1_data", last_data, 64'h98_7654_3210);
    check("lb1_count", 64'(last_cnt), 64'd40);
    check("lb1_error", 64'(last_err), 64'd0);

    v0 = valids;
    frame(1'b1, 40, 10, 128'h98_7654_3210, -1, 6);
    wait_clk(SYNC + 4);
    check("lb4_valids", 64'(valids - v0), 64'd1);
    check("lb4_data", last_data, 64'h98_7654_3210);
    check("lb4_count", 64'(last_cnt), 64'd40);

    frame(1'b0, 16, 8, 128'hC3, -1, 6);
    wait_clk(SYNC + 4);
    check("short_data", last_data, 64'hC3);
    check("short_count", 64'(last_cnt), 64'd8);
    check("short_error", 64'(last_err), 64'd1);
    check("short_overflow", 64'(last_ovf), 64'd0);

    frame(1'b0, 5, 68, 128'hA_0123_4567_89AB_CDEF, -1, 6);
    wait_clk(SYNC + 4);
    check("ovf_data", last_data, 64'h0123_4567_89AB_CDEF);
    check("ovf_count", 64'(last_cnt), 64'd64);
    check("ovf_flag", 64'(last_ovf), 64'd1);

    frame(1'b0, 0, 0, 128'h0, -1, 6);
    wait_clk(SYNC + 4);
    check("empty_data", last_data, 64'd0);
    check("empty_error", 64'(last_err), 64'd0);

    v0 = valids;
    frame(1'b0, 40, 40, 128'h11_2233_4455, 12, 6);
    wait_clk(SYNC + 4);
    check("abort_valids", 64'(valids - v0), 64'd0);
    frame(1'b0, 40, 40, 128'hDE_ADBE_EF01, -1, 6);
    wait_clk(SYNC + 4);
    check("after_abort_data", last_data, 64'hDE_ADBE_EF01);
    check("after_abort_count", 64'(last_cnt), 64'd40);

    v0 = valids;
    frame(1'b1, 8, 2, 128'h5A, -1, 3);
    frame(1'b0, 4, 4, 128'h9, -1, 6);
    wait_clk(SYNC + 4);
    check("b2b_valids", 64'(valids - v0), 64'd2);
    check("b2b_data", last_data, 64'h9);

    repeat (40) begin
      mode  = int'($urandom_range(0, 1));
      edges = int'($urandom_range(0, 20));
      total = edges * (mode != 0 ? 4 : 1);
      pl    = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1 && total <= 63) be = total;
      else be = int'($urandom_range(0, 63));
      frame(1'(mode), be, edges, pl, -1, int'($urandom_range(1, 6)));
    end

    wait_clk(SYNC + 6);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
